// File: rtl/lookup3_pkg.sv
// Shared constants, state encoding and tail-masking helper for the lookup3 key feeder.
package lookup3_pkg;

  localparam int unsigned MAX_KEY_LEN = 250;
  localparam int unsigned BLK_BYTES   = 12;
  localparam int unsigned MAX_BLKS    = 21;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    EMIT,
    DROP
  } state_t;

  // Byte-enable mask for word 'word' of a block with 'rem' bytes left in the key.
  function automatic logic [31:0] tail_mask(input logic [7:0] rem, input int unsigned word);
    logic [31:0] m;
    m = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      if (32'(rem) > (word * 32'd4 + b)) m[8*b +: 8] = 8'hFF;
    end
    return m;
  endfunction

endpackage

// File: rtl/lookup3_key_feeder_if.sv
// Key word input stream and 12-byte block output stream of the lookup3 key feeder.
interface lookup3_key_feeder_if;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic [2:0]  s_bytes;
  logic        s_last;

  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_k0;
  logic [31:0] m_k1;
  logic [31:0] m_k2;
  logic [7:0]  m_key_length;
  logic [7:0]  m_remain;
  logic        m_first;
  logic        m_last;

  modport slave (
    input  s_valid, s_data, s_bytes, s_last, m_ready,
    output s_ready, m_valid, m_k0, m_k1, m_k2, m_key_length, m_remain, m_first, m_last
  );

  modport master (
    output s_valid, s_data, s_bytes, s_last, m_ready,
    input  s_ready, m_valid, m_k0, m_k1, m_k2, m_key_length, m_remain, m_first, m_last
  );
endinterface

// File: rtl/key_buf_ram.sv
// Key word store: one write port, three combinational read ports, no reset.
module key_buf_ram #(
  parameter int unsigned DEPTH = 63,
  parameter int unsigned AW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr0,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  output logic [31:0]   rdata0_c,
  output logic [31:0]   rdata1_c,
  output logic [31:0]   rdata2_c
);
  import lookup3_pkg::*;

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Addresses past the end only occur on speculative reads whose data is discarded.
  assign rdata0_c = (32'(raddr0) < DEPTH) ? mem[raddr0] : '0;
  assign rdata1_c = (32'(raddr1) < DEPTH) ? mem[raddr1] : '0;
  assign rdata2_c = (32'(raddr2) < DEPTH) ? mem[raddr2] : '0;

endmodule

// File: rtl/lookup3_key_feeder.sv
// Collects a byte key word by word, then replays it as zero-padded 12-byte blocks for lookup3.
module lookup3_key_feeder #(
  parameter int unsigned MAX_KEY_LEN = lookup3_pkg::MAX_KEY_LEN,
  parameter int unsigned MAX_BLKS    = lookup3_pkg::MAX_BLKS
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  lookup3_key_feeder_if.slave  bus,
  output logic                 o_err
);
  import lookup3_pkg::*;

  localparam int unsigned DEPTH = 3 * MAX_BLKS;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned BW    = $clog2(MAX_BLKS + 1);

  state_t           state_q, state_d;
  logic [7:0]       len_q, len_d;
  logic [AW-1:0]    widx_q, widx_d;
  logic [BW-1:0]    blk_q, blk_d;
  logic             s_ready_q, s_ready_d;
  logic             m_valid_q, m_valid_d;
  logic [2:0][31:0] k_q, k_d;
  logic [7:0]       key_len_q, key_len_d;
  logic [7:0]       remain_q, remain_d;
  logic             first_q, first_d;
  logic             last_q, last_d;
  logic             err_q, err_d;
  logic             load_blk;

  logic             acc, we;
  logic [7:0]       add, new_len, nxt_rem;
  logic [8:0]       sum;
  logic [BW-1:0]    rd_blk;
  logic [AW-1:0]    rd_base, raddr0, raddr1, raddr2;
  logic [31:0]      rdata0_c, rdata1_c, rdata2_c;
  logic [2:0][31:0] word;

  assign acc     = bus.s_valid & s_ready_q;
  assign we      = acc & ((state_q == IDLE) | (state_q == LOAD));
  assign add     = bus.s_last ? {5'd0, bus.s_bytes} : 8'd4;
  assign sum     = {1'b0, len_q} + {1'b0, add};
  assign new_len = sum[8] ? 8'hFF : sum[7:0];

  // Read the block about to be presented: block 0 on key entry, else the successor.
  assign rd_blk  = (state_q == EMIT) ? blk_q + BW'(1) : '0;
  assign rd_base = AW'(32'(rd_blk) * 32'd3);
  assign raddr0  = rd_base;
  assign raddr1  = rd_base + AW'(1);
  assign raddr2  = rd_base + AW'(2);
  assign nxt_rem = (state_q == EMIT) ? remain_q - 8'(BLK_BYTES) : new_len;

  key_buf_ram #(.DEPTH(DEPTH), .AW(AW)) u_buf (
    .clk      (CLK),
    .we       (we),
    .waddr    (widx_q),
    .wdata    (bus.s_data),
    .raddr0   (raddr0),
    .raddr1   (raddr1),
    .raddr2   (raddr2),
    .rdata0_c (rdata0_c),
    .rdata1_c (rdata1_c),
    .rdata2_c (rdata2_c)
  );

  // The final key word is written in the same cycle block 0 is loaded, so bypass it.
  always_comb begin
    word[0] = (we && (widx_q == raddr0)) ? bus.s_data : rdata0_c;
    word[1] = (we && (widx_q == raddr1)) ? bus.s_data : rdata1_c;
    word[2] = (we && (widx_q == raddr2)) ? bus.s_data : rdata2_c;
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    widx_d    = widx_q;
    blk_d     = blk_q;
    m_valid_d = m_valid_q;
    k_d       = k_q;
    key_len_d = key_len_q;
    remain_d  = remain_q;
    first_d   = first_q;
    last_d    = last_q;
    err_d     = 1'b0;
    load_blk  = 1'b0;

    unique case (state_q)
      IDLE, LOAD: begin
        if (acc) begin
          widx_d = widx_q + AW'(1);
          len_d  = new_len;
          if (bus.s_last) begin
            if (32'(new_len) > MAX_KEY_LEN) begin
              state_d = IDLE;
              err_d   = 1'b1;
            end else if (new_len == 8'd0) begin
              state_d = IDLE;
            end else begin
              state_d   = EMIT;
              blk_d     = '0;
              key_len_d = new_len;
              first_d   = 1'b1;
              load_blk  = 1'b1;
            end
          end else if ((32'(new_len) > MAX_KEY_LEN) || (widx_q == AW'(DEPTH - 1))) begin
            state_d = DROP;
          end else begin
            state_d = LOAD;
          end
        end
      end
      DROP: begin
        if (acc && bus.s_last) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      EMIT: begin
        if (m_valid_q && bus.m_ready) begin
          if (last_q) begin
            state_d   = IDLE;
            m_valid_d = 1'b0;
            k_d       = '0;
            key_len_d = '0;
            remain_d  = '0;
            first_d   = 1'b0;
            last_d    = 1'b0;
          end else begin
            blk_d    = blk_q + BW'(1);
            first_d  = 1'b0;
            load_blk = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_blk) begin
      m_valid_d = 1'b1;
      remain_d  = nxt_rem;
      last_d    = (nxt_rem <= 8'(BLK_BYTES));
      for (int unsigned j = 0; j < 3; j++) k_d[j] = word[j] & tail_mask(nxt_rem, j);
    end

    if (state_d == IDLE) begin
      len_d  = '0;
      widx_d = '0;
    end
    s_ready_d = (state_d != EMIT);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      len_q     <= '0;
      widx_q    <= '0;
      blk_q     <= '0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      k_q       <= '0;
      key_len_q <= '0;
      remain_q  <= '0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      widx_q    <= widx_d;
      blk_q     <= blk_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      k_q       <= k_d;
      key_len_q <= key_len_d;
      remain_q  <= remain_d;
      first_q   <= first_d;
      last_q    <= last_d;
      err_q     <= err_d;
    end
  end

  assign bus.s_ready      = s_ready_q;
  assign bus.m_valid      = m_valid_q;
  assign bus.m_k0         = k_q[0];
  assign bus.m_k1         = k_q[1];
  assign bus.m_k2         = k_q[2];
  assign bus.m_key_length = key_len_q;
  assign bus.m_remain     = remain_q;
  assign bus.m_first      = first_q;
  assign bus.m_last       = last_q;
  assign o_err            = err_q;

endmodule

// File: tb/tb_lookup3_key_feeder.sv
// Randomized self-checking bench for lookup3_key_feeder against a byte-queue block model.
module tb_lookup3_key_feeder;

  logic clk;
  logic rst_n;
  logic err;
  int   vectors;
  int   miscompares;
  logic [7:0] cur_key[$];

  lookup3_key_feeder_if bus();

  lookup3_key_feeder #(.MAX_KEY_LEN(250), .MAX_BLKS(21)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus),
    .o_err (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [113:0] obs();
    return {bus.m_k0, bus.m_k1, bus.m_k2, bus.m_key_length, bus.m_remain, bus.m_first, bus.m_last};
  endfunction

  // Expected block b: key bytes laid out little-endian, zero beyond the key end.
  function automatic logic [113:0] model_blk(input int b);
    int n, nb, idx;
    logic [31:0] k [3];
    n  = cur_key.size();
    nb = (n + 11) / 12;
    for (int j = 0; j < 3; j++) begin
      k[j] = '0;
      for (int by = 0; by < 4; by++) begin
        idx = 12 * b + 4 * j + by;
        if (idx < n) k[j][8*by +: 8] = cur_key[idx];
      end
    end
    return {k[0], k[1], k[2], 8'(n), 8'(n - 12 * b), (b == 0), (b == nb - 1)};
  endfunction

  task automatic new_key(input int n);
    cur_key.delete();
    for (int i = 0; i < n; i++) cur_key.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic send_key();
    int n, nw, idx, guard;
    logic [31:0] d;
    n  = cur_key.size();
    nw = (n + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.s_valid = 1'b0;
        @(posedge clk); #1;
      end
      for (int by = 0; by < 4; by++) begin
        idx = 4 * w + by;
        d[8*by +: 8] = (idx < n) ? cur_key[idx] : 8'($urandom_range(0, 255));
      end
      bus.s_data  = d;
      bus.s_last  = (w == nw - 1);
      bus.s_bytes = (w == nw - 1) ? 3'(n - 4 * w) : 3'd4;
      bus.s_valid = 1'b1;
      guard = 0;
      @(negedge clk);
      while (bus.s_ready !== 1'b1 && guard < 200) begin
        guard++;
        @(negedge clk);
      end
      if (guard >= 200) begin
        vectors++;
        miscompares++;
        $display("FAIL send_timeout: s_ready=%b want 1 (word %0d of %0d)", bus.s_ready, w, nw);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic collect(input int stall_blk, input bit rnd);
    int n, nb, i, cyc, stall_left;
    logic [113:0] got, snap, exp_v;
    bit have_snap, rdy;
    n = cur_key.size(); nb = (n + 11) / 12;
    i = 0; cyc = 0; stall_left = 5; have_snap = 0;
    vectors++;
    if (bus.m_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL emit_latency: m_valid=%b want 1", bus.m_valid);
    end
    while (i < nb && cyc < 400) begin
      got = obs();
      if (have_snap) begin
        vectors++;
        if (bus.m_valid !== 1'b1 || got !== snap) begin
          miscompares++;
          $display("FAIL hold blk%0d: got %h v=%b want %h v=1", i, got, bus.m_valid, snap);
        end
        have_snap = 0;
      end
      if (i == stall_blk && stall_left > 0) begin
        rdy = 1'b0;
        stall_left--;
      end else if (rnd) rdy = ($urandom_range(0, 2) != 0);
      else rdy = 1'b1;
      bus.m_ready = rdy;
      if (bus.m_valid === 1'b1 && rdy) begin
        exp_v = model_blk(i);
        vectors++;
        if (got !== exp_v) begin
          miscompares++;
          $display("FAIL block len%0d blk%0d: got %h want %h", n, i, got, exp_v);
        end
        i++;
      end else if (bus.m_valid === 1'b1) begin
        snap = got;
        have_snap = 1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.m_ready = 1'b0;
    if (i < nb) begin
      vectors++;
      miscompares++;
      $display("FAIL collect_timeout: got %0d blocks want %0d", i, nb);
    end
    if (!rnd) begin
      vectors++;
      if (cyc != nb + ((stall_blk >= 0) ? 5 : 0)) begin
        miscompares++;
        $display("FAIL block_rate: %0d cycles want %0d", cyc, nb + ((stall_blk >= 0) ? 5 : 0));
      end
    end
    vectors++;
    if (bus.m_valid !== 1'b0 || bus.s_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL post_emit: m_valid=%b s_ready=%b want 0 1", bus.m_valid, bus.s_ready);
    end
  endtask

  task automatic expect_drop();
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("FAIL drop_err len%0d: o_err=%b want 1", cur_key.size(), err);
    end
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      vectors++;
      if (err !== 1'b0 || bus.m_valid !== 1'b0 || bus.s_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL drop_after: o_err=%b m_valid=%b s_ready=%b want 0 0 1", err, bus.m_valid, bus.s_ready);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.s_valid = 1'b0; bus.s_last = 1'b0; bus.s_data = '0; bus.s_bytes = 3'd4;
    bus.m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (obs() !== 114'd0 || bus.m_valid !== 1'b0 || bus.s_ready !== 1'b0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: out=%h v=%b rdy=%b err=%b want all 0", obs(), bus.m_valid, bus.s_ready, err);
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (bus.s_ready !== 1'b1 || bus.m_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: s_ready=%b m_valid=%b want 1 0", bus.s_ready, bus.m_valid);
    end
  endtask

  task automatic test_abc();
    cur_key.delete();
    cur_key.push_back(8'h61); cur_key.push_back(8'h62); cur_key.push_back(8'h63);
    send_key();
    vectors++;
    if ({bus.m_k0, bus.m_k1, bus.m_k2} !== {32'h00636261, 64'd0} || bus.m_key_length !== 8'd3 ||
        bus.m_remain !== 8'd3 || bus.m_first !== 1'b1 || bus.m_last !== 1'b1) begin
      miscompares++;
      $display("FAIL abc: got %h want k0=00636261 len=3 rem=3 first=last=1", obs());
    end
    collect(-1, 1'b0);
  endtask

  task automatic test_exact_blocks();
    cur_key.delete();
    for (int i = 0; i < 12; i++) cur_key.push_back(8'(i));
    send_key();
    vectors++;
    if ({bus.m_k0, bus.m_k1, bus.m_k2} !== {32'h03020100, 32'h07060504, 32'h0B0A0908}) begin
      miscompares++;
      $display("FAIL twelve: got %h want 03020100 07060504 0b0a0908", {bus.m_k0, bus.m_k1, bus.m_k2});
    end
    collect(-1, 1'b0);
    cur_key.push_back(8'h0C);
    send_key();
    collect(-1, 1'b0);
  endtask

  task automatic test_max_len();
    new_key(250); send_key(); collect(-1, 1'b0);
    new_key(251); send_key(); expect_drop();
    new_key(300); send_key(); expect_drop();
    new_key(249); send_key(); collect(-1, 1'b1);
  endtask

  task automatic test_stall();
    new_key(48); send_key(); collect(1, 1'b0);
  endtask

  task automatic test_back_to_back();
    new_key(120); send_key(); collect(-1, 1'b0);
    new_key(25);  send_key(); collect(-1, 1'b0);
  endtask

  task automatic test_random();
    int n;
    for (int t = 0; t < 40; t++) begin
      n = (t % 4 == 0) ? 240 + int'($urandom_range(0, 20)) : int'($urandom_range(1, 260));
      new_key(n);
      send_key();
      if (n > 250) expect_drop();
      else collect(-1, 1'b1);
    end
  endtask

  task automatic test_reset_emit();
    new_key(40); send_key();
    bus.m_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.m_ready = 1'b0;
    vectors++;
    if (obs() !== model_blk(2)) begin
      miscompares++;
      $display("FAIL pre_reset_blk2: got %h want %h", obs(), model_blk(2));
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (obs() !== 114'd0 || bus.m_valid !== 1'b0 || bus.s_ready !== 1'b0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_emit: out=%h v=%b rdy=%b want all 0", obs(), bus.m_valid, bus.s_ready);
    end
    @(posedge clk); @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (bus.m_valid !== 1'b0 || bus.s_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_emit_release: m_valid=%b s_ready=%b want 0 1", bus.m_valid, bus.s_ready);
    end
    new_key(3); send_key(); collect(-1, 1'b1);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_abc();
    test_exact_blocks();
    test_max_len();
    test_stall();
    test_back_to_back();
    test_random();
    test_reset_emit();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete, %0d miscompares so far", miscompares);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/lookup3_key_feeder.md
LOOKUP3_KEY_FEEDER -- requirements
Module: lookup3_key_feeder

Interface
REQ-001 SHALL have parameter MAX_KEY_LEN, default 250, giving the maximum key length in bytes.
REQ-002 SHALL have parameter MAX_BLKS, default 21, giving the buffer depth in 12-byte blocks.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 CLK  in  1  sole clock, rising edge.
REQ-005 RST_N  in  1  asynchronous active-low reset.
REQ-006 s_valid  in  1  input key word valid.
REQ-007 s_ready  out  1  feeder accepts input word this cycle.
REQ-008 s_data  in  32  key bytes, little-endian (byte0 = [7:0]).
REQ-009 s_bytes  in  3  valid bytes in word, 1..4; only sampled with s_last, otherwise 4.
REQ-010 s_last  in  1  final word of key.
REQ-011 m_valid  out  1  block valid toward hash pipeline.
REQ-012 m_ready  in  1  hash pipeline accepts block.
REQ-013 m_k0, m_k1, m_k2  out  32 each  key block words (bytes 0-3, 4-7, 8-11 of block).
REQ-014 m_key_length  out  8  total key length, constant across all blocks of one key.
REQ-015 m_remain  out  8  bytes remaining from this block onward (key_length - 12*index).
REQ-016 m_first, m_last  out  1 each  first/last block of key.
REQ-017 o_err  out  1  one-cycle pulse: key dropped for over-length.

Function
REQ-018 SHALL implement states IDLE, LOAD, EMIT, DROP.
REQ-019 IDLE: s_ready=1; first accepted word -> LOAD (or EMIT if s_last).
REQ-020 LOAD: s_ready=1; each handshake (s_valid&s_ready) stores word at next word index, adds 4 (or s_bytes on s_last) to 8-bit length counter.
REQ-021 On accepted s_last with total length <= MAX_KEY_LEN -> EMIT; m_valid SHALL assert the next cycle.
REQ-022 Length > MAX_KEY_LEN, or word index reaching 3*MAX_BLKS without s_last -> DROP; counter SHALL saturate, not wrap.
REQ-023 DROP: s_ready=1, words discarded; on accepted s_last -> IDLE with o_err pulsed that cycle; no block emitted.
REQ-024 EMIT: s_ready=0; blocks issued in order index 0..ceil(len/12)-1.
REQ-025 Bytes beyond key length within last block SHALL read as zero, including stale buffer contents.
REQ-026 Length an exact multiple of 12 SHALL produce no trailing empty block.
REQ-027 m_valid, all m_* data SHALL hold stable while m_valid & !m_ready.
REQ-028 Block advances only on m_valid & m_ready; on last-block handshake -> IDLE, s_ready=1 the next cycle.
REQ-029 Sustained m_ready=1 SHALL give one block per cycle.

Reset
REQ-030 RST_N low SHALL force IDLE, s_ready=0 while asserted, then 1; m_valid=0, m_k*=0, m_key_length=0, m_remain=0, m_first=0, m_last=0, o_err=0, counters 0.
REQ-031 Reset mid-LOAD or mid-EMIT SHALL abandon the key; no partial block appears after release.
REQ-032 Buffer contents need no reset; masking per REQ-025 covers stale data.

Structure
REQ-033 Package lookup3_pkg SHALL hold MAX_KEY_LEN, BLK_BYTES=12, MAX_BLKS=21, and the state enumeration.
REQ-034 Word storage SHALL be sub-module key_buf_ram: 3*MAX_BLKS x 32 registers, 1 write port, 3 combinational read ports.

Verification
REQ-035 Key "abc" (one word 0x??636261, s_bytes=3, s_last) -> one block k0=0x00636261, k1=k2=0, len=3, remain=3, first=last=1.
REQ-036 12-byte key 0x03020100,0x07060504,0x0B0A0908 -> exactly one block with those words, len=12, first=last=1.
REQ-037 13-byte key -> two blocks; second k0=0x0000000C, k1=k2=0, remain=1, last=1.
REQ-038 250-byte key -> 21 blocks, remain 250,238,...,10; 251-byte key -> o_err pulse, zero blocks, feeder back in IDLE.
REQ-039 m_ready low 5 cycles mid-EMIT -> block 1 held bit-stable, then blocks resume without loss or duplication.
REQ-040 RST_N asserted during EMIT of block 2 -> all outputs zero immediately; next 3-byte key emits cleanly with zeroed padding.
